// File: rtl/bnn_ctrl_pkg.sv
// Shared types and constants for the BNN control path: sequencer states,
// host command bytes and frame geometry.
package bnn_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_IMAGE,
        START,
        INFER,
        RESULT
    } seq_state_t;

    localparam logic [7:0] CMD_IMAGE = 8'hA5;
    localparam logic [7:0] CMD_CLEAR = 8'h5A;

    localparam int IMG_BYTES_DEFAULT = 113;
    localparam int CLASS_W           = 4;

endpackage

// File: rtl/inference_sequencer.sv
// Command decode, image streaming, BNN start/done handshake with timeout,
// and the registered host-side status outputs.
module inference_sequencer
    import bnn_ctrl_pkg::*;
#(
    parameter int IMG_BYTES     = IMG_BYTES_DEFAULT,
    parameter int ADDR_W        = 7,
    parameter int INFER_TIMEOUT = 1048576
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_valid,
    input  logic [7:0]         rx_byte,
    input  logic               cs_active,
    output logic               buf_we,
    output logic [ADDR_W-1:0]  buf_addr,
    output logic [7:0]         buf_wdata,
    output logic               bnn_start,
    input  logic               bnn_done,
    input  logic [CLASS_W-1:0] bnn_class,
    output logic [CLASS_W-1:0] result_out,
    output logic               result_ready,
    output logic               send_image,
    output logic               status_ready,
    output logic               error,
    output seq_state_t         dbg_state
);

    localparam int CNT_W = $clog2(IMG_BYTES + 1);
    localparam int TMO_W = $clog2(INFER_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(INFER_TIMEOUT);

    seq_state_t         r_state;
    seq_state_t         w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_cs_prev;
    logic               r_buf_we;
    logic [ADDR_W-1:0]  r_buf_addr;
    logic [7:0]         r_buf_wdata;
    logic               r_bnn_start;
    logic [CLASS_W-1:0] r_result;
    logic               r_result_ready;
    logic               r_send_image;
    logic               r_status_ready;
    logic               r_error;

    logic w_cmd_image;
    logic w_cmd_clear;
    logic w_cs_fall;
    logic w_last;
    logic w_timeout;
    logic w_wr;
    logic w_error_nxt;

    assign w_cmd_image = rx_valid && (rx_byte == CMD_IMAGE);
    assign w_cmd_clear = rx_valid && (rx_byte == CMD_CLEAR);
    assign w_cs_fall   = r_cs_prev && !cs_active;
    assign w_last      = (r_cnt == LAST_IDX);
    assign w_timeout   = (r_tmo == TMO_MAX);
    assign w_wr        = (r_state == RX_IMAGE) && rx_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The completing byte takes priority over a simultaneous chip-select fall.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_cmd_image) w_next = RX_IMAGE;
            RX_IMAGE: begin
                if (rx_valid && w_last) w_next = START;
                else if (w_cs_fall)     w_next = IDLE;
            end
            START:    w_next = INFER;
            INFER: begin
                if (bnn_done)       w_next = RESULT;
                else if (w_timeout) w_next = IDLE;
            end
            RESULT: begin
                if (w_cmd_image)      w_next = RX_IMAGE;
                else if (w_cmd_clear) w_next = IDLE;
            end
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        w_error_nxt = r_error;
        if ((r_state == IDLE) && (w_cmd_image || w_cmd_clear)) w_error_nxt = 1'b0;
        if ((r_state == RX_IMAGE) && w_cs_fall && !(rx_valid && w_last)) w_error_nxt = 1'b1;
        if (((r_state == START) || (r_state == INFER)) && rx_valid) w_error_nxt = 1'b1;
        if ((r_state == INFER) && !bnn_done && w_timeout) w_error_nxt = 1'b1;
    end

    // Host flags are registered from the next state so they track it with no lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_tmo          <= '0;
            r_cs_prev      <= 1'b0;
            r_buf_we       <= 1'b0;
            r_buf_addr     <= '0;
            r_buf_wdata    <= '0;
            r_bnn_start    <= 1'b0;
            r_result       <= '0;
            r_result_ready <= 1'b0;
            r_send_image   <= 1'b0;
            r_status_ready <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_cs_prev <= cs_active;
            if ((w_next == RX_IMAGE) && (r_state != RX_IMAGE)) begin
                r_cnt <= '0;
            end else if (w_wr && !w_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == START) begin
                r_tmo <= '0;
            end else if ((r_state == INFER) && !w_timeout) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
            r_buf_we <= w_wr;
            if (w_wr) begin
                r_buf_addr  <= ADDR_W'(r_cnt);
                r_buf_wdata <= rx_byte;
            end
            r_bnn_start <= (r_state == START);
            if ((r_state == INFER) && bnn_done) begin
                r_result <= bnn_class;
            end
            r_result_ready <= (w_next == RESULT);
            r_send_image   <= (w_next == RX_IMAGE);
            r_status_ready <= (w_next == IDLE) || (w_next == RESULT);
            r_error        <= w_error_nxt;
        end
    end

    assign buf_we       = r_buf_we;
    assign buf_addr     = r_buf_addr;
    assign buf_wdata    = r_buf_wdata;
    assign bnn_start    = r_bnn_start;
    assign result_out   = r_result;
    assign result_ready = r_result_ready;
    assign send_image   = r_send_image;
    assign status_ready = r_status_ready;
    assign error        = r_error;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_inference_sequencer.sv
// Self-checking bench for inference_sequencer: scenario tasks against a
// frame-level reference model and a buffer-write scoreboard.
module tb_inference_sequencer;
  import bnn_ctrl_pkg::*;

  localparam int IMG = 113;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       cs_active = 1'b0;
  logic       bnn_done = 1'b0;
  logic [3:0] bnn_class = 4'h0;
  logic       buf_we;
  logic [6:0] buf_addr;
  logic [7:0] buf_wdata;
  logic       bnn_start;
  logic [3:0] result_out;
  logic       result_ready;
  logic       send_image;
  logic       status_ready;
  logic       error;
  seq_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int frame_start_base = 0;
  logic [14:0] exp_q[$];
  logic [3:0] m_result = 4'h0;
  logic       m_error = 1'b0;

  inference_sequencer #(
    .IMG_BYTES(IMG), .ADDR_W(7), .INFER_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .cs_active(cs_active), .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata), .bnn_start(bnn_start), .bnn_done(bnn_done),
    .bnn_class(bnn_class), .result_out(result_out), .result_ready(result_ready),
    .send_image(send_image), .status_ready(status_ready), .error(error),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired, simulation did not finish");
    $fatal(1, "watchdog");
  end

  // scoreboard: every buffer write must match the next expected {addr,data}
  always @(negedge clk) begin
    if (rst_n) begin
      if (bnn_start) start_cnt++;
      if (buf_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0d data=%02h required no write", buf_addr, buf_wdata);
        end else begin
          logic [14:0] e;
          e = exp_q.pop_front();
          if ({buf_addr, buf_wdata} !== e) begin
            errors++;
            $display("FAIL buf_write addr=%0d data=%02h required addr=%0d data=%02h",
                     buf_addr, buf_wdata, e[14:8], e[7:0]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    bnn_class = 4'($urandom_range(0, 15));
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
    rx_byte  = 8'($urandom_range(0, 255));
  endtask

  // A5 + full frame; returns in the cycle where bnn_start is visible
  task automatic run_frame(input bit from_idle, input bit random_data, input bit gaps,
                           input bit cs_drop_last);
    logic [7:0] b;
    frame_start_base = start_cnt;
    if (from_idle) m_error = 1'b0;
    cs_active = 1'b1;
    send_byte(CMD_IMAGE);
    checks++;
    if ({send_image, status_ready, result_ready, error} !== {3'b100, m_error}) begin
      errors++;
      $display("FAIL cmd_image_decode got snd/st/rr/err=%b%b%b%b required %b%b%b%b",
               send_image, status_ready, result_ready, error, 1'b1, 1'b0, 1'b0, m_error);
    end
    for (int i = 0; i < IMG; i++) begin
      b = random_data ? 8'($urandom_range(0, 255)) : 8'(i);
      exp_q.push_back({7'(i), b});
      rx_valid = 1'b1;
      rx_byte  = b;
      if (i == IMG - 1 && cs_drop_last) cs_active = 1'b0;
      tick();
      rx_valid = 1'b0;
      if (gaps && i != IMG - 1) repeat ($urandom_range(0, 2)) tick();
    end
    checks++;
    if ({send_image, status_ready, bnn_start, buf_we, error} !== {4'b0001, m_error}) begin
      errors++;
      $display("FAIL last_byte got snd/st/start/we/err=%b%b%b%b%b required 0001%b",
               send_image, status_ready, bnn_start, buf_we, error, m_error);
    end
    tick();
    cs_active = 1'b1;
    checks++;
    if ({bnn_start, status_ready, send_image} !== 3'b100) begin
      errors++;
      $display("FAIL start_pulse got start/st/snd=%b%b%b required 100",
               bnn_start, status_ready, send_image);
    end
  endtask

  task automatic do_done(input int d, input logic [3:0] cls);
    repeat (d) tick();
    bnn_done  = 1'b1;
    bnn_class = cls;
    tick();
    bnn_done = 1'b0;
    m_result = cls;
    checks++;
    if ({result_out, result_ready, status_ready, send_image, error} !== {cls, 3'b110, m_error}) begin
      errors++;
      $display("FAIL result got class=%0h rr/st/snd/err=%b%b%b%b required class=%0h 110%b",
               result_out, result_ready, status_ready, send_image, error, cls, m_error);
    end
    checks++;
    if (start_cnt !== frame_start_base + 1) begin
      errors++;
      $display("FAIL start_count got %0d required %0d", start_cnt - frame_start_base, 1);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({buf_we, bnn_start, result_out, result_ready, send_image, status_ready, error} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b required all 0",
               {buf_we, bnn_start, result_out, result_ready, send_image, status_ready, error});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({status_ready, buf_we, bnn_start, result_out, result_ready, send_image, error} !== 10'b1000000000) begin
      errors++;
      $display("FAIL reset_release got %b required 1000000000",
               {status_ready, buf_we, bnn_start, result_out, result_ready, send_image, error});
    end
  endtask

  task automatic test_normal_frame();
    run_frame(1'b1, 1'b0, 1'b0, 1'b0);
    do_done(3, 4'h7);
  endtask

  task automatic test_result_cycling();
    logic [3:0] cls;
    cls = 4'($urandom_range(8, 15));
    run_frame(1'b0, 1'b1, 1'b0, 1'b0);
    do_done($urandom_range(0, TMO), cls);
    send_byte(CMD_CLEAR);
    checks++;
    if ({status_ready, result_ready, send_image, result_out} !== {3'b100, m_result}) begin
      errors++;
      $display("FAIL clear_from_result got st/rr/snd=%b%b%b class=%0h required 100 class=%0h",
               status_ready, result_ready, send_image, result_out, m_result);
    end
  endtask

  task automatic test_abort();
    int s0;
    s0 = start_cnt;
    cs_active = 1'b1;
    m_error = 1'b0;
    send_byte(CMD_IMAGE);
    for (int i = 0; i < 50; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      exp_q.push_back({7'(i), b});
      send_byte(b);
    end
    cs_active = 1'b0;
    tick();
    m_error = 1'b1;
    checks++;
    if ({error, status_ready, send_image} !== 3'b110) begin
      errors++;
      $display("FAIL abort got err/st/snd=%b%b%b required 110", error, status_ready, send_image);
    end
    repeat (4) tick();
    checks++;
    if (start_cnt !== s0) begin
      errors++;
      $display("FAIL abort_no_start got %0d starts required 0", start_cnt - s0);
    end
    cs_active = 1'b1;
    send_byte(CMD_IMAGE);
    m_error = 1'b0;
    checks++;
    if ({error, send_image} !== 2'b01) begin
      errors++;
      $display("FAIL abort_clear got err/snd=%b%b required 01", error, send_image);
    end
    cs_active = 1'b0;
    tick();
    send_byte(CMD_CLEAR);
    checks++;
    if ({error, status_ready} !== 2'b01) begin
      errors++;
      $display("FAIL clear_cmd got err/st=%b%b required 01", error, status_ready);
    end
  endtask

  task automatic test_timeout();
    run_frame(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (TMO) tick();
    checks++;
    if ({status_ready, error} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_early got st/err=%b%b at start+%0d required 00", status_ready, error, TMO);
    end
    tick();
    m_error = 1'b1;
    checks++;
    if ({error, status_ready, result_ready, result_out} !== {3'b110, m_result}) begin
      errors++;
      $display("FAIL timeout got err/st/rr=%b%b%b class=%0h required 110 class=%0h",
               error, status_ready, result_ready, result_out, m_result);
    end
    bnn_done  = 1'b1;
    bnn_class = ~m_result;
    tick();
    bnn_done = 1'b0;
    tick();
    checks++;
    if ({result_ready, status_ready, result_out} !== {2'b01, m_result}) begin
      errors++;
      $display("FAIL late_done got rr/st=%b%b class=%0h required 01 class=%0h",
               result_ready, status_ready, result_out, m_result);
    end
    // bnn_done in the expiry cycle wins over the timeout
    run_frame(1'b1, 1'b1, 1'b1, 1'b0);
    do_done(TMO, 4'($urandom_range(0, 15)));
  endtask

  task automatic test_rx_in_infer();
    run_frame(1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'h33);
    m_error = 1'b1;
    checks++;
    if ({error, send_image, status_ready, result_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL rx_in_infer got err/snd/st/rr=%b%b%b%b required 1000",
               error, send_image, status_ready, result_ready);
    end
    do_done(5, 4'($urandom_range(0, 15)));
    send_byte(CMD_CLEAR);
    send_byte(CMD_CLEAR);
    m_error = 1'b0;
    checks++;
    if ({error, status_ready, result_out} !== {2'b01, m_result}) begin
      errors++;
      $display("FAIL clear_after_fault got err/st=%b%b class=%0h required 01 class=%0h",
               error, status_ready, result_out, m_result);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) begin
      run_frame(f == 0, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
      do_done($urandom_range(0, TMO), 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic test_async_reset();
    run_frame(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    m_result = 4'h0;
    m_error  = 1'b0;
    checks++;
    if ({buf_we, bnn_start, result_out, result_ready, send_image, status_ready, error} !== 10'b0) begin
      errors++;
      $display("FAIL async_reset got %b required all 0",
               {buf_we, bnn_start, result_out, result_ready, send_image, status_ready, error});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({status_ready, error, result_ready, result_out} !== 7'b1000000) begin
      errors++;
      $display("FAIL post_reset_idle got st/err/rr=%b%b%b class=%0h required 100 class=0",
               status_ready, error, result_ready, result_out);
    end
    cs_active = 1'b1;
    send_byte(CMD_IMAGE);
    checks++;
    if ({send_image, status_ready} !== 2'b10) begin
      errors++;
      $display("FAIL post_reset_cmd got snd/st=%b%b required 10", send_image, status_ready);
    end
    cs_active = 1'b0;
    tick();
    send_byte(CMD_CLEAR);
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_result_cycling();
    test_abort();
    test_timeout();
    test_rx_in_infer();
    test_back_to_back();
    test_async_reset();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes got %0d outstanding required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
